midi_note_receiver: RTL and testbench

MIDI_NOTE_RECEIVER -- requirements
Module: midi_note_receiver

---
 rtl/midi_pkg.sv | 17 +
 rtl/midi_uart_rx.sv | 105 ++++++++++
 rtl/midi_note_receiver.sv | 88 ++++++++
 tb/tb_midi_note_receiver.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared types and constants for the MIDI note receiver.
// Holds the UART state encoding and the MIDI status/realtime thresholds.
package midi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_state_t;

  localparam logic [3:0] MIDI_NOTE_OFF     = 4'h8;
  localparam logic [3:0] MIDI_NOTE_ON      = 4'h9;
  localparam logic [7:0] MIDI_REALTIME_MIN = 8'hF8;

endpackage

// File: rtl/midi_uart_rx.sv
// 8N1 UART receiver behind a 2-flop synchronizer; byte_valid/framing_err pulse
// one cycle after the stop-bit sample. No backpressure: every byte must be taken.
module midi_uart_rx
  import midi_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 31250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       midi_rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       framing_err
);

  localparam int BIT_CYC  = CLK_HZ / BAUD;
  localparam int HALF_CYC = BIT_CYC / 2;
  localparam int CW       = $clog2(BIT_CYC + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYC - 1);

  logic          sync1, sync2;
  uart_state_t   state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          half_done, bit_done;
  logic          valid_nxt, ferr_nxt;

  // Reset to the idle (high) line level so no spurious start bit is seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= midi_rx;
      sync2 <= sync1;
    end
  end

  assign half_done = (cnt == HALF_LAST);
  assign bit_done  = (cnt == BIT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!sync2) state_nxt = START;
      START:     if (half_done) state_nxt = sync2 ? IDLE : DATA;
      DATA:      if (bit_done && bit_idx == 3'd7) state_nxt = STOP;
      STOP:      if (bit_done) state_nxt = sync2 ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (sync2) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;
    if (state == STOP && bit_done) begin
      valid_nxt = sync2;
      ferr_nxt  = !sync2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      bit_idx     <= 3'd0;
      shift       <= 8'h00;
      byte_valid  <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      byte_valid  <= valid_nxt;
      framing_err <= ferr_nxt;
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= 3'd0;
        end
        START: cnt <= half_done ? '0 : cnt + CW'(1);
        DATA: begin
          if (bit_done) begin
            cnt     <= '0;
            shift   <= {sync2, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP:    cnt <= bit_done ? '0 : cnt + CW'(1);
        default: cnt <= '0;
      endcase
    end
  end

  // The shifter only moves in DATA, so the byte is stable while byte_valid is high.
  assign byte_data = shift;

endmodule

// File: rtl/midi_note_receiver.sv
// MIDI note decoder: UART bytes -> note/velocity/gate with running status and
// last-note priority. Outputs update 1 cycle after byte_valid; no backpressure.
module midi_note_receiver
  import midi_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 31250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       midi_rx,
  input  logic [3:0] channel,
  input  logic       omni,
  output logic [6:0] note,
  output logic [6:0] velocity,
  output logic       gate,
  output logic       note_valid,
  output logic       framing_err
);

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic [7:0] run_status;
  logic       key_held;
  logic [6:0] key;
  logic       is_realtime, is_system, note_msg;
  logic [3:0] kind;

  midi_uart_rx #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) u_uart (
    .clk        (clk),
    .reset      (reset),
    .midi_rx    (midi_rx),
    .byte_data  (rx_byte),
    .byte_valid (byte_valid),
    .framing_err(framing_err)
  );

  // run_status == 0 means "no running status"; it can never match a note kind.
  assign kind        = run_status[7:4];
  assign is_realtime = (rx_byte >= MIDI_REALTIME_MIN);
  assign is_system   = (rx_byte[7:4] == 4'hF) && !is_realtime;
  assign note_msg    = ((kind == MIDI_NOTE_ON) || (kind == MIDI_NOTE_OFF)) &&
                       (omni || (run_status[3:0] == channel));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_status <= 8'h00;
      key_held   <= 1'b0;
      key        <= 7'd0;
      note       <= 7'd0;
      velocity   <= 7'd0;
      gate       <= 1'b0;
      note_valid <= 1'b0;
    end else begin
      note_valid <= 1'b0;
      if (byte_valid && !is_realtime) begin
        if (is_system) begin
          run_status <= 8'h00;
          key_held   <= 1'b0;
        end else if (rx_byte[7]) begin
          run_status <= rx_byte;
          key_held   <= 1'b0;
        end else if (note_msg) begin
          if (!key_held) begin
            key      <= rx_byte[6:0];
            key_held <= 1'b1;
          end else begin
            key_held <= 1'b0;
            if (kind == MIDI_NOTE_ON && rx_byte[6:0] != 7'd0) begin
              note       <= key;
              velocity   <= rx_byte[6:0];
              gate       <= 1'b1;
              note_valid <= 1'b1;
            end else if (key == note) begin
              // Release only the sounding note; stale releases are dropped.
              gate       <= 1'b0;
              note_valid <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_midi_note_receiver.sv
// Bench for midi_note_receiver: directed scenarios plus randomized messages
// compared against a byte-level behavioural model of the MIDI note parser.
module tb_midi_note_receiver;

  localparam int BAUD   = 31250;
  localparam int BIT    = 16;
  localparam int HALF   = BIT / 2;
  localparam int CLK_HZ = BAUD * BIT;
  // Line edge -> 2 sync flops -> idle detect -> half bit -> 9 bit periods = stop sample.
  localparam int FE_LAT = 3 + HALF + 9 * BIT;
  localparam int NV_LAT = FE_LAT + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       midi_rx;
  logic [3:0] channel;
  logic       omni;
  logic [6:0] note, velocity;
  logic       gate, note_valid, framing_err;

  always #5 clk = ~clk;

  midi_note_receiver #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .midi_rx    (midi_rx),
    .channel    (channel),
    .omni       (omni),
    .note       (note),
    .velocity   (velocity),
    .gate       (gate),
    .note_valid (note_valid),
    .framing_err(framing_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nv_count = 0, fe_count = 0, last_nv_cyc = 0, last_fe_cyc = 0;
  int byte_cyc, nv0, fe0, upd0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (note_valid) begin
        nv_count    <= nv_count + 1;
        last_nv_cyc <= cyc;
      end
      if (framing_err) begin
        fe_count    <= fe_count + 1;
        last_fe_cyc <= cyc;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: running status as an int (-1 = none), pending data bytes in a queue.
  int m_rs, m_note, m_vel, m_gate, m_upd;
  int m_pend[$];

  task automatic model_reset();
    m_rs = -1; m_note = 0; m_vel = 0; m_gate = 0;
    m_pend.delete();
  endtask

  task automatic model_byte(input int b);
    int k, v;
    if (b >= 'hF8) begin
    end else if (b >= 'hF0) begin
      m_rs = -1;
      m_pend.delete();
    end else if (b >= 'h80) begin
      m_rs = b;
      m_pend.delete();
    end else if (m_rs >= 0 && (m_rs / 16 == 8 || m_rs / 16 == 9) &&
                 (omni || (m_rs % 16) == int'(channel))) begin
      m_pend.push_back(b);
      if (m_pend.size() == 2) begin
        k = m_pend[0];
        v = m_pend[1];
        m_pend.delete();
        if (m_rs / 16 == 9 && v > 0) begin
          m_note = k; m_vel = v; m_gate = 1; m_upd++;
        end else if (k == m_note) begin
          m_gate = 0; m_upd++;
        end
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    @(posedge clk); #1;
    byte_cyc = cyc;
    midi_rx  = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 midi_rx = b[i];
      repeat (BIT) @(posedge clk);
    end
    #1 midi_rx = stop_ok;
    repeat (BIT) @(posedge clk);
    #1 midi_rx = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    if (stop_ok) model_byte(int'(b));
  endtask

  task automatic snap();
    nv0 = nv_count; fe0 = fe_count; upd0 = m_upd;
  endtask

  task automatic check_model(input string tag);
    check({tag, " note"}, 32'(note), 32'(m_note));
    check({tag, " velocity"}, 32'(velocity), 32'(m_vel));
    check({tag, " gate"}, 32'(gate), 32'(m_gate));
    check({tag, " note_valid count"}, 32'(nv_count - nv0), 32'(m_upd - upd0));
    check({tag, " framing_err count"}, 32'(fe_count - fe0), 32'd0);
  endtask

  logic [7:0] q[$];
  logic [7:0] kbyte;
  logic [3:0] ch;
  logic [6:0] rkey, rvel;
  int         kind;

  initial begin
    m_upd   = 0;
    model_reset();
    reset   = 1'b1;
    midi_rx = 1'b1;
    channel = 4'd0;
    omni    = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("reset note", 32'(note), 32'd0);
    check("reset velocity", 32'(velocity), 32'd0);
    check("reset gate", 32'(gate), 32'd0);
    check("reset note_valid", 32'(note_valid), 32'd0);
    check("reset framing_err", 32'(framing_err), 32'd0);
    reset = 1'b0;
    repeat (4) @(posedge clk);

    // Basic Note On with exact latency
    snap();
    send_byte(8'h90, 1'b1); send_byte(8'h38, 1'b1); send_byte(8'h14, 1'b1);
    check("on note", 32'(note), 32'd56);
    check("on velocity", 32'(velocity), 32'd20);
    check("on gate", 32'(gate), 32'd1);
    check("on note_valid count", 32'(nv_count - nv0), 32'd1);
    check("on latency", 32'(last_nv_cyc - byte_cyc), 32'(NV_LAT));

    // Running status
    snap();
    send_byte(8'h3C, 1'b1); send_byte(8'h40, 1'b1);
    check("rs note", 32'(note), 32'd60);
    check("rs velocity", 32'(velocity), 32'd64);
    check("rs gate", 32'(gate), 32'd1);
    check("rs note_valid count", 32'(nv_count - nv0), 32'd1);

    // Stale Note Off for a key that is no longer sounding
    snap();
    send_byte(8'h80, 1'b1); send_byte(8'h38, 1'b1); send_byte(8'h00, 1'b1);
    check("stale off note", 32'(note), 32'd60);
    check("stale off gate", 32'(gate), 32'd1);
    check("stale off note_valid count", 32'(nv_count - nv0), 32'd0);

    snap();
    send_byte(8'h3C, 1'b1); send_byte(8'h00, 1'b1);
    check("off gate", 32'(gate), 32'd0);
    check("off note", 32'(note), 32'd60);
    check("off velocity", 32'(velocity), 32'd64);
    check("off note_valid count", 32'(nv_count - nv0), 32'd1);

    // Realtime byte between key and velocity
    snap();
    send_byte(8'h90, 1'b1); send_byte(8'h40, 1'b1); send_byte(8'hF8, 1'b1); send_byte(8'h7F, 1'b1);
    check("realtime note", 32'(note), 32'd64);
    check("realtime velocity", 32'(velocity), 32'd127);
    check("realtime gate", 32'(gate), 32'd1);
    check("realtime note_valid count", 32'(nv_count - nv0), 32'd1);

    // Channel filter, then omni
    snap();
    send_byte(8'h91, 1'b1); send_byte(8'h40, 1'b1); send_byte(8'h50, 1'b1);
    check("reject note_valid count", 32'(nv_count - nv0), 32'd0);
    check("reject velocity", 32'(velocity), 32'd127);
    omni = 1'b1;
    snap();
    send_byte(8'h91, 1'b1); send_byte(8'h40, 1'b1); send_byte(8'h50, 1'b1);
    check("omni note", 32'(note), 32'd64);
    check("omni velocity", 32'(velocity), 32'd80);
    check("omni note_valid count", 32'(nv_count - nv0), 32'd1);
    omni = 1'b0;

    // Framing error
    snap();
    send_byte(8'h45, 1'b0);
    check("ferr count", 32'(fe_count - fe0), 32'd1);
    check("ferr latency", 32'(last_fe_cyc - byte_cyc), 32'(FE_LAT));
    check("ferr note_valid count", 32'(nv_count - nv0), 32'd0);
    check("ferr note", 32'(note), 32'd64);
    check("ferr velocity", 32'(velocity), 32'd80);
    snap();
    send_byte(8'h90, 1'b1); send_byte(8'h3E, 1'b1); send_byte(8'h22, 1'b1);
    check("after ferr note", 32'(note), 32'd62);
    check("after ferr velocity", 32'(velocity), 32'd34);
    check("after ferr fe count", 32'(fe_count - fe0), 32'd0);

    // Reset during bit 4 of a key byte
    send_byte(8'h90, 1'b1);
    kbyte = 8'h45;
    @(posedge clk); #1 midi_rx = 1'b0;
    repeat (BIT) @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      #1 midi_rx = kbyte[i];
      repeat (BIT) @(posedge clk);
    end
    #1 midi_rx = kbyte[4];
    repeat (HALF) @(posedge clk);
    #1 reset = 1'b1;
    midi_rx = 1'b1;
    model_reset();
    repeat (3) @(posedge clk); #1;
    check("midreset note", 32'(note), 32'd0);
    check("midreset velocity", 32'(velocity), 32'd0);
    check("midreset gate", 32'(gate), 32'd0);
    check("midreset note_valid", 32'(note_valid), 32'd0);
    reset = 1'b0;
    repeat (2 * BIT) @(posedge clk);
    snap();
    send_byte(8'h90, 1'b1); send_byte(8'h30, 1'b1); send_byte(8'h10, 1'b1);
    check("postreset note", 32'(note), 32'd48);
    check("postreset velocity", 32'(velocity), 32'd16);
    check("postreset gate", 32'(gate), 32'd1);
    check("postreset note_valid count", 32'(nv_count - nv0), 32'd1);

    // Randomized messages against the model
    for (int m = 0; m < 30; m++) begin
      if ($urandom_range(0, 7) == 0) channel = 4'($urandom_range(0, 15));
      omni = ($urandom_range(0, 4) == 0);
      ch   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : channel;
      rkey = 7'($urandom_range(0, 127));
      rvel = ($urandom_range(0, 4) == 0) ? 7'd0 : 7'($urandom_range(1, 127));
      kind = $urandom_range(0, 4);
      q.delete();
      case (kind)
        0: q.push_back({4'h9, ch});
        1: begin
          q.push_back({4'h8, ch});
          if ($urandom_range(0, 1) == 1) rkey = 7'(m_note);
        end
        2: ;
        3: q.push_back(8'(8'hF0 + $urandom_range(0, 7)));
        default: q.push_back({4'($urandom_range(10, 14)), ch});
      endcase
      q.push_back({1'b0, rkey});
      q.push_back({1'b0, rvel});
      snap();
      for (int i = 0; i < q.size(); i++) begin
        if ($urandom_range(0, 4) == 0) send_byte(8'(8'hF8 + $urandom_range(0, 7)), 1'b1);
        send_byte(q[i], 1'b1);
      end
      check_model($sformatf("rand%0d", m));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
